// File: rtl/list_sum_ctrl.sv
// Control sequencer for the linked-list summing datapath: walks the list from address 0,
// counts nodes, and stops on a null pointer, on abort, or when the node limit trips the watchdog.
module list_sum_ctrl #(
    parameter int CNT_W     = 8,
    parameter int MAX_NODES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             next_zero,
    output logic             LOAD_SUM,
    output logic             LOAD_NEXT,
    output logic             SUM_SEL,
    output logic             NEXT_SEL,
    output logic             ADDR_SEL,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] node_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_ADD  = 3'd2;
    localparam logic [2:0] S_NEXT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_NODES);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_INIT: begin
                state_d = abort ? S_IDLE : S_ADD;
            end
            S_ADD: begin
                // The sum register loads on this edge, so the node is counted even if aborted.
                if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
                state_d = abort ? S_IDLE : S_NEXT;
            end
            S_NEXT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (next_zero) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_ADD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        LOAD_SUM  = 1'b0;
        LOAD_NEXT = 1'b0;
        SUM_SEL   = 1'b0;
        NEXT_SEL  = 1'b0;
        ADDR_SEL  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_INIT: begin
                LOAD_SUM  = 1'b1;
                LOAD_NEXT = 1'b1;
                busy      = 1'b1;
            end
            S_ADD: begin
                LOAD_SUM = 1'b1;
                SUM_SEL  = 1'b1;
                ADDR_SEL = 1'b1;
                busy     = 1'b1;
            end
            S_NEXT: begin
                LOAD_NEXT = 1'b1;
                NEXT_SEL  = 1'b1;
                busy      = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign err      = err_q;
    assign node_cnt = cnt_q;

endmodule
